cmd_byte_fifo: RTL and testbench

CMD_BYTE_FIFO -- requirements
Module: cmd_byte_fifo

---
 rtl/cmd_byte_fifo_pkg.sv | 29 ++
 rtl/cmd_fifo_ram.sv | 27 ++
 rtl/cmd_byte_fifo.sv | 124 ++++++++++++
 tb/tb_cmd_byte_fifo.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_byte_fifo_pkg.sv
// Shared constants and helpers for the command byte FIFO.
// A controller-wide header may pre-define CMD_FIFO_DEPTH / CMD_FIFO_AF_MARGIN to override the defaults.
`ifndef CMD_FIFO_DEPTH
`define CMD_FIFO_DEPTH 16
`endif

`ifndef CMD_FIFO_AF_MARGIN
`define CMD_FIFO_AF_MARGIN 2
`endif

package cmd_byte_fifo_pkg;

  localparam int FIFO_DEPTH_DFLT     = `CMD_FIFO_DEPTH;
  localparam int FIFO_AF_MARGIN_DFLT = `CMD_FIFO_AF_MARGIN;

  localparam int BYTE_W = 8;

  // Per-cycle decision: what the FIFO actually does with the strobes it sees.
  typedef struct packed {
    logic push;
    logic pop;
    logic drop;
  } fifo_op_t;

  function automatic logic [BYTE_W-1:0] sat_inc8(input logic [BYTE_W-1:0] v);
    return (v == {BYTE_W{1'b1}}) ? v : v + BYTE_W'(1);
  endfunction

endpackage

// File: rtl/cmd_fifo_ram.sv
// DEPTH x 8 storage for the command FIFO: synchronous write, asynchronous read.
module cmd_fifo_ram
  import cmd_byte_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DFLT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);

  // Contents are deliberately not reset.
  logic [BYTE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cmd_byte_fifo.sv
// Show-ahead byte FIFO between the host serial receiver and the command controller.
// Define CMD_FIFO_OVF_COUNT_EN to add the saturating overflow_count output.
module cmd_byte_fifo
  import cmd_byte_fifo_pkg::*;
#(
  parameter int DEPTH              = FIFO_DEPTH_DFLT,
  parameter int ALMOST_FULL_MARGIN = FIFO_AF_MARGIN_DFLT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [BYTE_W-1:0]         wr_byte,
  input  logic                      wr_valid,
  input  logic                      flush,
  input  logic                      next,
  output logic [BYTE_W-1:0]         in_byte,
  output logic                      in_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      almost_full,
  output logic                      overflow,
  input  logic                      clear_overflow
`ifdef CMD_FIFO_OVF_COUNT_EN
  ,
  output logic [BYTE_W-1:0]         overflow_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [31:0] AF_MARGIN = ALMOST_FULL_MARGIN;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [LW-1:0] free_slots;
  logic          empty, full;
  fifo_op_t      op;

  cmd_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (op.push),
    .waddr (wr_ptr_q),
    .wdata (wr_byte),
    .raddr (rd_ptr_q),
    .rdata (in_byte)
  );

  // At full, a concurrent pop frees the slot the push needs, so nothing is dropped.
  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == LW'(DEPTH));
    op      = '0;
    op.pop  = next && !empty && !flush;
    op.push = wr_valid && (!full || (next && !empty)) && !flush;
    op.drop = wr_valid && full && !next && !flush;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (op.push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (op.pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({op.push, op.pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    // A same-cycle drop wins over the clear request.
    if (clear_overflow) overflow_d = 1'b0;
    if (op.drop)        overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef CMD_FIFO_OVF_COUNT_EN
  logic [BYTE_W-1:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (clear_overflow) ovf_cnt_d = '0;
    if (op.drop)        ovf_cnt_d = sat_inc8(ovf_cnt_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign overflow_count = ovf_cnt_q;
`endif

  assign free_slots  = LW'(DEPTH) - level_q;
  assign almost_full = (32'(free_slots) <= AF_MARGIN);
  assign in_ready    = !empty;
  assign level       = level_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_cmd_byte_fifo.sv
// Self-checking bench for cmd_byte_fifo against a queue-based reference model.
// Build with +define+CMD_FIFO_OVF_COUNT_EN to also exercise overflow_count.
module tb_cmd_byte_fifo;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    wr_byte = 8'h00;
  logic          wr_valid = 1'b0;
  logic          flush = 1'b0;
  logic          next = 1'b0;
  logic          clear_overflow = 1'b0;
  logic [7:0]    in_byte;
  logic          in_ready;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          overflow;
`ifdef CMD_FIFO_OVF_COUNT_EN
  logic [7:0]    overflow_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  byte unsigned q[$];
  bit           m_ovf = 1'b0;
  int           m_cnt = 0;

  always #5 clk = ~clk;

  cmd_byte_fifo #(
    .DEPTH              (DEPTH),
    .ALMOST_FULL_MARGIN (MARGIN)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_byte        (wr_byte),
    .wr_valid       (wr_valid),
    .flush          (flush),
    .next           (next),
    .in_byte        (in_byte),
    .in_ready       (in_ready),
    .level          (level),
    .almost_full    (almost_full),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
`ifdef CMD_FIFO_OVF_COUNT_EN
    ,
    .overflow_count (overflow_count)
`endif
  );

  // One clock edge; the model consumes the inputs that were held across it.
  task automatic tick();
    bit pop_ok;
    bit drop;
    @(posedge clk);
    #1;
    drop = 1'b0;
    if (flush) begin
      q.delete();
    end else begin
      pop_ok = next && (q.size() > 0);
      if (wr_valid && q.size() == DEPTH && !pop_ok) drop = 1'b1;
      if (pop_ok) void'(q.pop_front());
      if (wr_valid && !drop) q.push_back(wr_byte);
    end
    if (clear_overflow) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    if (drop) begin
      m_ovf = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic idle();
    wr_valid = 1'b0; next = 1'b0; flush = 1'b0; clear_overflow = 1'b0;
  endtask

  task automatic push(input logic [7:0] b);
    wr_byte = b; wr_valid = 1'b1; tick(); wr_valid = 1'b0;
  endtask

  task automatic drain();
    idle(); flush = 1'b1; clear_overflow = 1'b1; tick(); idle();
  endtask

  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    #12;
    n_vec++; if (level !== '0)        begin n_err++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_vec++; if (in_ready !== 1'b0)   begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    n_vec++; if (overflow !== 1'b0)   begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_vec++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    push(8'h01);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready got=%b exp=1", in_ready); end
    n_vec++; if (in_byte !== 8'h01) begin n_err++; $display("FAIL basic_byte got=%h exp=01", in_byte); end
    tick();
    next = 1'b1; tick(); next = 1'b0;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_pop_ready got=%b exp=0", in_ready); end
    next = 1'b1; tick(); next = 1'b0;
    n_vec++; if (level !== '0) begin n_err++; $display("FAIL basic_empty_pop_level got=%0d exp=0", level); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    n_vec++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL ovf_almost_full got=%b exp=1", almost_full); end
    push(8'h20);
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    n_vec++; if (level !== LW'(16)) begin n_err++; $display("FAIL ovf_level got=%0d exp=16", level); end
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (in_byte !== 8'(8'h10 + i)) begin
        n_err++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, in_byte, 8'(8'h10 + i));
      end
      next = 1'b1; tick(); next = 1'b0;
    end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ovf_drained got=%b exp=0", in_ready); end
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    wr_byte = 8'hAA; wr_valid = 1'b1; next = 1'b1; tick(); idle();
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpp_overflow got=%b exp=0", overflow); end
    n_vec++; if (level !== LW'(16)) begin n_err++; $display("FAIL fullpp_level got=%0d exp=16", level); end
    n_vec++; if (in_byte !== 8'h41) begin n_err++; $display("FAIL fullpp_head got=%h exp=41", in_byte); end
    for (int i = 0; i < 15; i++) begin next = 1'b1; tick(); end
    next = 1'b0;
    n_vec++; if (in_byte !== 8'hAA || level !== LW'(1)) begin
      n_err++; $display("FAIL fullpp_last got=%h/%0d exp=aa/1", in_byte, level);
    end
    drain();
  endtask

  task automatic test_empty_push_pop();
    wr_byte = 8'h55; wr_valid = 1'b1; next = 1'b1; tick(); idle();
    n_vec++; if (level !== LW'(1))  begin n_err++; $display("FAIL emptypp_level got=%0d exp=1", level); end
    n_vec++; if (in_byte !== 8'h55) begin n_err++; $display("FAIL emptypp_byte got=%h exp=55", in_byte); end
    drain();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    wr_byte = 8'h77; wr_valid = 1'b1; flush = 1'b1; next = 1'b1; tick(); idle();
    n_vec++; if (level !== '0)      begin n_err++; $display("FAIL flush_level got=%0d exp=0", level); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    push(8'h33);
    n_vec++; if (in_byte !== 8'h33 || level !== LW'(1)) begin
      n_err++; $display("FAIL flush_next_head got=%h/%0d exp=33/1", in_byte, level);
    end
    drain();
  endtask

  task automatic test_random();
    int wr_pct;
    bit exp_af;
    for (int i = 0; i < 3000; i++) begin
      case ((i / 250) % 3)
        0:       wr_pct = 85;
        1:       wr_pct = 50;
        default: wr_pct = 20;
      endcase
      wr_byte        = 8'($urandom);
      wr_valid       = ($urandom_range(0, 99) < wr_pct);
      next           = ($urandom_range(0, 99) < (100 - wr_pct));
      flush          = ($urandom_range(0, 99) == 0);
      clear_overflow = ($urandom_range(0, 39) == 0);
      tick();
      exp_af = ((DEPTH - q.size()) <= MARGIN);
      n_vec++; if (level !== LW'(q.size())) begin n_err++; $display("FAIL rnd_level[%0d] got=%0d exp=%0d", i, level, q.size()); end
      n_vec++; if (in_ready !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, in_ready, q.size() > 0); end
      n_vec++; if (almost_full !== exp_af) begin n_err++; $display("FAIL rnd_af[%0d] got=%b exp=%b", i, almost_full, exp_af); end
      n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf[%0d] got=%b exp=%b", i, overflow, m_ovf); end
      if (q.size() > 0) begin
        n_vec++; if (in_byte !== q[0]) begin n_err++; $display("FAIL rnd_head[%0d] got=%h exp=%h", i, in_byte, q[0]); end
      end
`ifdef CMD_FIFO_OVF_COUNT_EN
      n_vec++; if (overflow_count !== 8'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, overflow_count, m_cnt); end
`endif
    end
    idle();
    drain();
  endtask

`ifdef CMD_FIFO_OVF_COUNT_EN
  task automatic test_ovf_count();
    for (int i = 0; i < 16; i++) push(8'(i));
    for (int i = 0; i < 3; i++) push(8'hEE);
    n_vec++; if (overflow_count !== 8'd3) begin n_err++; $display("FAIL cnt_three got=%0d exp=3", overflow_count); end
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    n_vec++; if (overflow_count !== 8'd0) begin n_err++; $display("FAIL cnt_clear got=%0d exp=0", overflow_count); end
    wr_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    wr_valid = 1'b0;
    n_vec++; if (overflow_count !== 8'd255) begin n_err++; $display("FAIL cnt_sat got=%0d exp=255", overflow_count); end
  endtask
`endif

  task automatic test_async_reset();
    if (q.size() < DEPTH) begin
      for (int i = q.size(); i < DEPTH; i++) push(8'(8'h60 + i));
    end
    push(8'hEF);
    wr_byte = 8'h5A; wr_valid = 1'b1; next = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (level !== '0)         begin n_err++; $display("FAIL arst_level got=%0d exp=0", level); end
    n_vec++; if (in_ready !== 1'b0)    begin n_err++; $display("FAIL arst_ready got=%b exp=0", in_ready); end
    n_vec++; if (overflow !== 1'b0)    begin n_err++; $display("FAIL arst_overflow got=%b exp=0", overflow); end
    n_vec++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL arst_af got=%b exp=0", almost_full); end
`ifdef CMD_FIFO_OVF_COUNT_EN
    n_vec++; if (overflow_count !== 8'd0) begin n_err++; $display("FAIL arst_cnt got=%0d exp=0", overflow_count); end
`endif
    idle();
    q.delete(); m_ovf = 1'b0; m_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    wr_byte = 8'h9C; wr_valid = 1'b1; next = 1'b1; tick(); idle();
    n_vec++; if (level !== LW'(1) || in_byte !== 8'h9C) begin
      n_err++; $display("FAIL arst_first got=%0d/%h exp=1/9c", level, in_byte);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_flush();
    test_random();
`ifdef CMD_FIFO_OVF_COUNT_EN
    test_ovf_count();
`endif
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
